// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: operand/result handshake bundle for alu_muldiv.
//    flush     : synchronous abort (master -> slave)
//    in_valid  : A, B, alu_op valid (master -> slave)
//    in_ready  : slave can accept an operation (slave -> master)
//    A, B      : operands, WIDTH bits (master -> slave)
//    alu_op    : 5-bit operation select (master -> slave)
//    out_valid : result holds a completed operation (slave -> master)
//    out_ready : consumer takes result (master -> slave)
//    result    : WIDTH-bit result (slave -> master)
interface alu_muldiv_if #(
   parameter int WIDTH = 32
) ();
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [4:0]       alu_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   modport master (
      output flush, in_valid, A, B, alu_op, out_ready,
      input  in_ready, out_valid, result
   );
   modport slave (
      input  flush, in_valid, A, B, alu_op, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: single-issue ALU with iterative shift-add multiplier and restoring divider.
//    clk   : rising-edge clock
//    rst_n : asynchronous active-low reset
//    bus   : alu_muldiv_if slave (flush, in_valid/in_ready, A, B, alu_op,
//            out_valid/out_ready, result)
module alu_muldiv #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic         clk,
   input logic         rst_n,
   alu_muldiv_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   state_t               r_state;
   logic [CW-1:0]        r_cnt;
   logic [4:0]           r_op;
   logic                 r_neg;
   logic [WIDTH-1:0]     r_b;
   logic [WIDTH-1:0]     r_result;
   logic [2*WIDTH-1:0]   r_prod;
   logic [SHW-1:0]       w_sh;
   logic [WIDTH-1:0]     w_simple, w_imm, w_a_mag, w_b_mag, w_qr, w_fin;
   logic                 w_is_mul, w_is_div, w_sa, w_sb, w_rem, w_neg, w_dz, w_ovf;
   logic [WIDTH:0]       w_sum, w_dsh, w_dif;
   logic [2*WIDTH-1:0]   w_mul_nx, w_div_nx, w_pf;

   assign bus.in_ready  = (r_state == IDLE) && !bus.flush;
   assign bus.out_valid = (r_state == DONE);
   assign bus.result    = r_result;

   assign w_sh     = bus.B[SHW-1:0];
   assign w_is_mul = bus.alu_op inside {[10:13]};
   assign w_is_div = bus.alu_op inside {[14:17]};
   // Which operands are treated as signed; the iterative core works on magnitudes.
   assign w_sa     = bus.alu_op inside {11, 12, 14, 16};
   assign w_sb     = bus.alu_op inside {11, 14, 16};
   assign w_rem    = bus.alu_op inside {16, 17};
   assign w_a_mag  = (w_sa && bus.A[WIDTH-1]) ? -bus.A : bus.A;
   assign w_b_mag  = (w_sb && bus.B[WIDTH-1]) ? -bus.B : bus.B;
   // Remainder sign follows A only; products and quotients follow A xor B.
   assign w_neg    = (bus.alu_op == 5'd16) ? (w_sa & bus.A[WIDTH-1])
                                           : ((w_sa & bus.A[WIDTH-1]) ^ (w_sb & bus.B[WIDTH-1]));
   assign w_dz     = (bus.B == '0);
   assign w_ovf    = (bus.alu_op inside {14, 16}) && (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.B);
   assign w_imm    = w_is_div ? (w_dz ? (w_rem ? bus.A : '1) : (w_rem ? '0 : bus.A)) : w_simple;

   always_comb begin
      w_simple = '0;
      case (bus.alu_op)
         5'd0:    w_simple = bus.A + bus.B;
         5'd1:    w_simple = bus.A << w_sh;
         5'd2:    w_simple = WIDTH'($signed(bus.A) < $signed(bus.B));
         5'd3:    w_simple = WIDTH'(bus.A < bus.B);
         5'd4:    w_simple = bus.A ^ bus.B;
         5'd5:    w_simple = bus.A >> w_sh;
         5'd6:    w_simple = WIDTH'($signed(bus.A) >>> w_sh);
         5'd7:    w_simple = bus.A | bus.B;
         5'd8:    w_simple = bus.A & bus.B;
         5'd9:    w_simple = bus.A - bus.B;
         default: w_simple = '0;
      endcase
   end

   // Shift-add: high half accumulates multiplicand, low half shifts out multiplier bits.
   assign w_sum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_b} : '0);
   assign w_mul_nx = {w_sum, r_prod[WIDTH-1:1]};
   // Restoring divide: high half is partial remainder, low half dividend/quotient.
   assign w_dsh    = r_prod[2*WIDTH-1:WIDTH-1];
   assign w_dif    = w_dsh - {1'b0, r_b};
   assign w_div_nx = {w_dif[WIDTH] ? w_dsh[WIDTH-1:0] : w_dif[WIDTH-1:0], r_prod[WIDTH-2:0], ~w_dif[WIDTH]};
   // The final step and the sign fix-up share one cycle.
   assign w_pf     = r_neg ? -w_mul_nx : w_mul_nx;
   assign w_qr     = (r_op inside {16, 17}) ? w_div_nx[2*WIDTH-1:WIDTH] : w_div_nx[WIDTH-1:0];
   assign w_fin    = (r_state == MUL) ? ((r_op == 5'd10) ? w_pf[WIDTH-1:0] : w_pf[2*WIDTH-1:WIDTH])
                                      : (r_neg ? -w_qr : w_qr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_op     <= '0;
         r_neg    <= 1'b0;
         r_b      <= '0;
         r_prod   <= '0;
         r_result <= '0;
      end else if (bus.flush) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: if (bus.in_valid) begin
               r_op   <= bus.alu_op;
               r_neg  <= w_neg;
               r_b    <= w_b_mag;
               r_prod <= {{WIDTH{1'b0}}, w_a_mag};
               r_cnt  <= '0;
               if (w_is_mul) r_state <= MUL;
               else if (w_is_div && !w_dz && !w_ovf) r_state <= DIV;
               else begin
                  r_result <= w_imm;
                  r_state  <= DONE;
               end
            end
            MUL, DIV: begin
               r_prod <= (r_state == MUL) ? w_mul_nx : w_div_nx;
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == CW'(WIDTH-1)) begin
                  r_result <= w_fin;
                  r_state  <= DONE;
               end
            end
            DONE: if (bus.out_ready) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: self-checking bench for 32- and 8-bit alu_muldiv instances.
module tb_alu_muldiv;
   typedef longint unsigned u64;
   typedef struct {
      bit          s;
      logic [4:0]  o;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] e;
      int          l;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [4:0]  op = '0;
   logic        ov, rdy;
   logic [31:0] res;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   alu_muldiv_if #(.WIDTH(32)) if32 ();
   alu_muldiv_if #(.WIDTH(8))  if8 ();

   alu_muldiv #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32));
   alu_muldiv #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(if8));

   assign if32.flush     = flush;
   assign if32.in_valid  = in_valid & ~sel;
   assign if32.out_ready = out_ready & ~sel;
   assign if32.A         = a;
   assign if32.B         = b;
   assign if32.alu_op    = op;
   assign if8.flush      = flush;
   assign if8.in_valid   = in_valid & sel;
   assign if8.out_ready  = out_ready & sel;
   assign if8.A          = a[7:0];
   assign if8.B          = b[7:0];
   assign if8.alu_op     = op;
   assign ov  = sel ? if8.out_valid : if32.out_valid;
   assign rdy = sel ? if8.in_ready  : if32.in_ready;
   assign res = sel ? {24'd0, if8.result} : if32.result;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Reference result from plain wide-integer arithmetic on a w-bit machine.
   function automatic logic [31:0] model(input int w, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
      u64 m, ua, ub, r;
      longint sa, sb;
      int sh;
      m  = (u64'(1) << w) - 1;
      ua = u64'(x) & m;
      ub = u64'(y) & m;
      sa = longint'(ua << (64 - w)) >>> (64 - w);
      sb = longint'(ub << (64 - w)) >>> (64 - w);
      sh = int'(ub % u64'(w));
      case (o)
         5'd0:    r = ua + ub;
         5'd1:    r = ua << sh;
         5'd2:    r = u64'(sa < sb);
         5'd3:    r = u64'(ua < ub);
         5'd4:    r = ua ^ ub;
         5'd5:    r = ua >> sh;
         5'd6:    r = u64'(sa >>> sh);
         5'd7:    r = ua | ub;
         5'd8:    r = ua & ub;
         5'd9:    r = ua - ub;
         5'd10:   r = ua * ub;
         5'd11:   r = u64'((sa * sb) >>> w);
         5'd12:   r = u64'((sa * longint'(ub)) >>> w);
         5'd13:   r = (ua * ub) >> w;
         5'd14:   r = (ub == 0) ? m : u64'(sa / sb);
         5'd15:   r = (ub == 0) ? m : ua / ub;
         5'd16:   r = (ub == 0) ? ua : u64'(sa % sb);
         5'd17:   r = (ub == 0) ? ua : ua % ub;
         default: r = 0;
      endcase
      return 32'(r & m);
   endfunction

   function automatic int model_lat(input int w, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sa, sb;
      u64 m;
      m  = (u64'(1) << w) - 1;
      sa = longint'((u64'(x) & m) << (64 - w)) >>> (64 - w);
      sb = longint'((u64'(y) & m) << (64 - w)) >>> (64 - w);
      if (o >= 10 && o <= 13) return w + 1;
      if (o >= 14 && o <= 17) begin
         if ((u64'(y) & m) == 0) return 1;
         if ((o == 14 || o == 16) && sa == -(longint'(1) << (w - 1)) && sb == -1) return 1;
         return w + 1;
      end
      return 1;
   endfunction

   // Called at a negedge; returns at the negedge right after the transfer edge.
   task automatic send(input bit s, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
      int n = 0;
      sel = s;
      #1;
      while (!rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", 32'(rdy), 32'd1);
      op = o;
      a = x;
      b = y;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      op = 5'($urandom);
   endtask

   task automatic collect(output logic [31:0] r, output int lat);
      lat = 1;
      while (!ov && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      r = res;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   function automatic logic [31:0] pick(input int w);
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'd1 << (w - 1);
         3:       return 32'($urandom_range(0, 9));
         default: return $urandom;
      endcase
   endfunction

   vec_t tbl [18];

   initial begin
      logic [31:0] r;
      int lat, seen;
      tbl = '{
         '{0, 5'd0,  32'hFFFFFFFF, 32'h1,        32'h00000000, 1},
         '{0, 5'd6,  32'h80000000, 32'h24,       32'hF8000000, 1},
         '{0, 5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33},
         '{0, 5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33},
         '{0, 5'd14, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 33},
         '{0, 5'd16, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 33},
         '{0, 5'd15, 32'h5,        32'h0,        32'hFFFFFFFF, 1},
         '{0, 5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
         '{0, 5'd16, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1},
         '{0, 5'd17, 32'h5,        32'h0,        32'h00000005, 1},
         '{0, 5'd12, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 33},
         '{0, 5'd2,  32'hFFFFFFFF, 32'h1,        32'h00000001, 1},
         '{0, 5'd3,  32'hFFFFFFFF, 32'h1,        32'h00000000, 1},
         '{0, 5'd20, 32'h1234,     32'h5678,     32'h00000000, 1},
         '{1, 5'd10, 32'h10,       32'h10,       32'h00000000, 9},
         '{1, 5'd13, 32'h10,       32'h10,       32'h00000001, 9},
         '{1, 5'd1,  32'h1,        32'h0B,       32'h00000008, 1},
         '{1, 5'd14, 32'h80,       32'hFF,       32'h00000080, 1}
      };

      repeat (2) @(negedge clk);
      chk("rst_ov32", 32'(if32.out_valid), 32'd0);
      chk("rst_res32", if32.result, 32'd0);
      chk("rst_ov8", 32'(if8.out_valid), 32'd0);
      chk("rst_res8", 32'(if8.result), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_rdy32", 32'(if32.in_ready), 32'd1);
      chk("rst_rdy8", 32'(if8.in_ready), 32'd1);

      foreach (tbl[i]) begin
         send(tbl[i].s, tbl[i].o, tbl[i].x, tbl[i].y);
         collect(r, lat);
         chk($sformatf("vec%0d_res", i), r, tbl[i].e);
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].l));
         consume();
      end

      for (int i = 0; i < 200; i++) begin
         bit s;
         int w;
         logic [4:0] o;
         logic [31:0] x, y;
         s = 1'($urandom_range(0, 1));
         w = s ? 8 : 32;
         o = $urandom_range(0, 1) ? 5'($urandom_range(10, 17)) : 5'($urandom_range(0, 31));
         x = pick(w);
         y = pick(w);
         send(s, o, x, y);
         collect(r, lat);
         chk($sformatf("rnd%0d_w%0d_op%0d_res", i, w, o), r, model(w, o, x, y));
         chk($sformatf("rnd%0d_w%0d_op%0d_lat", i, w, o), 32'(lat), 32'(model_lat(w, o, x, y)));
         consume();
      end

      send(0, 5'd0, 32'd2, 32'd3);
      chk("bp_ov", 32'(ov), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_ov", 32'(ov), 32'd1);
         chk("bp_hold_res", res, 32'd5);
         chk("bp_hold_rdy", 32'(rdy), 32'd0);
      end
      consume();
      chk("bp_after_rdy", 32'(rdy), 32'd1);
      chk("bp_after_ov", 32'(ov), 32'd0);

      send(0, 5'd15, 32'hDEADBEEF, 32'd7);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      #1;
      chk("flush_rdy_low", 32'(rdy), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (ov) seen++;
         @(negedge clk);
      end
      chk("flush_no_ov", 32'(seen), 32'd0);
      chk("flush_rdy", 32'(rdy), 32'd1);

      send(0, 5'd13, $urandom, $urandom);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_res", if32.result, 32'd0);
      chk("arst_ov", 32'(if32.out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (ov) seen++;
         @(negedge clk);
      end
      chk("arst_no_ov", 32'(seen), 32'd0);
      chk("arst_rdy", 32'(rdy), 32'd1);
      send(0, 5'd0, 32'd2, 32'd3);
      collect(r, lat);
      chk("post_add_res", r, 32'd5);
      chk("post_add_lat", 32'(lat), 32'd1);
      consume();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(WIDTH): number of low bits of B used as shift amount.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 flush  input  1: synchronous abort of any operation in flight.
REQ-006 in_valid  input  1: A, B and alu_op are valid this cycle.
REQ-007 in_ready  output  1: unit can accept an operation this cycle.
REQ-008 A, B  input  WIDTH each: operands.
REQ-009 alu_op  input  5: operation select.
REQ-010 out_valid  output  1: result holds a completed operation.
REQ-011 out_ready  input  1: consumer takes result this cycle.
REQ-012 result  output  WIDTH: operation result.

Function
REQ-013 Simple ops (1-cycle class): 0 ADD A+B; 1 SLL A<<B[SHW-1:0]; 2 SLT signed A<B (1/0); 3 SLTU unsigned A<B; 4 XOR; 5 SRL logical; 6 SRA arithmetic (sign-filled from A[WIDTH-1]); 7 OR; 8 AND; 9 SUB A-B.
REQ-014 Multiply ops: 10 MUL low WIDTH bits; 11 MULH high half signed x signed; 12 MULHSU high half signed A x unsigned B; 13 MULHU high half unsigned x unsigned.
REQ-015 Divide ops: 14 DIV signed quotient (truncate toward zero); 15 DIVU; 16 REM signed remainder (sign follows A); 17 REMU.
REQ-016 Codes 18-31: 1-cycle class, result 0.
REQ-017 All arithmetic is modulo 2^WIDTH; no overflow or carry flags.
REQ-018 States: IDLE, MUL, DIV, DONE.
REQ-019 in_ready = 1 only in IDLE and with flush low; transfer occurs when in_valid and in_ready are high at a rising edge.
REQ-020 IDLE, transfer of 1-cycle class: result registered, go to DONE; out_valid high the following cycle (latency 1).
REQ-021 IDLE, transfer of multiply op: operands latched (sign-adjusted per op), iteration counter cleared, go to MUL.
REQ-022 MUL: one radix-2 shift-add step per cycle; after WIDTH steps, sign-correct, write selected half, go to DONE; out_valid rises WIDTH+1 cycles after transfer.
REQ-023 IDLE, transfer of divide op with B != 0 and not signed overflow: go to DIV; one restoring step per cycle, WIDTH steps, then sign fix-up, DONE; out_valid rises WIDTH+1 cycles after transfer.
REQ-024 Divide by zero (B=0): no iteration; DONE next cycle; DIV/DIVU result all ones; REM/REMU result A.
REQ-025 Signed overflow (DIV/REM, A = most negative, B = all ones): no iteration; DONE next cycle; DIV result A; REM result 0.
REQ-026 DONE: out_valid = 1, result held stable until out_ready = 1; on that edge go to IDLE, out_valid falls.
REQ-027 No new operation accepted in the same cycle a result is consumed; next transfer earliest one cycle later.
REQ-028 In IDLE, MUL and DIV, out_valid = 0; result holds its last value.
REQ-029 flush high at an edge: go to IDLE from any state, discard in-flight or held result, out_valid = 0 next cycle; flush overrides in_valid and out_ready in the same cycle.
REQ-030 Changes to A, B or alu_op after transfer do not affect the operation in flight.

Reset
REQ-031 rst_n low immediately forces IDLE: out_valid = 0, result = 0, iteration counter = 0; in_ready = 1 while rst_n high and flush low.
REQ-032 Reset asserted mid-MUL/DIV discards the operation; first transfer after release behaves as from power-up.

Verification
REQ-033 WIDTH=32, ADD A=0xFFFFFFFF B=1 -> out_valid next cycle, result 0x00000000; SRA A=0x80000000 B=0x24 (shift 4) -> 0xF8000000.
REQ-034 MULH A=0xFFFFFFFF B=0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; out_valid exactly 33 cycles after transfer.
REQ-035 DIV A=-7 B=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU A=5 B=0 -> 0xFFFFFFFF, latency 1; DIV A=0x80000000 B=0xFFFFFFFF -> 0x80000000, latency 1.
REQ-036 Backpressure: result ready, out_ready low 5 cycles -> out_valid and result stable, in_ready 0 throughout; out_ready high -> in_ready 1 next cycle.
REQ-037 flush at iteration 10 of DIVU, then rst_n pulse during a MUL -> no out_valid for either, in_ready 1 after each, following ADD 2+3 -> 5.
REQ-038 WIDTH=8 instance: MUL 0x10 x 0x10 -> 0x00, MULHU -> 0x01, latency 9; SLL A=1 B=0x0B (shift 3) -> 0x08.
